inst_mem_responder: RTL
=======================

Name: inst_mem_responder

Overview:
Instruction-memory responder: the memory side of the fetch-stage interface (MEM_CLK read strobe, MEM_ADDR, MEM_OUT). A single-cycle MEM_CLK strobe triggers a synchronous read. The read word is returned one CLK later and held stable. A streaming load port fills the array before or between program runs. Sits between the program loader / testbench and the instruction fetch stage.

Parameters:
ADDR_W, 16, width of MEM_ADDR and load address
DATA_W, 32, instruction word width
DEPTH, 256, number of words; must be a power of two and no larger than 2^ADDR_W

Ports:
CLK  in  1  clock; all state changes on posedge
RST  in  1  reset, synchronous, active-low
MEM_CLK  in  1  read strobe from fetch; level sampled on CLK
MEM_ADDR  in  ADDR_W  word address; valid while MEM_CLK=1
MEM_OUT  out  DATA_W  registered read data
RD_CNT  out  16  number of reads accepted; wraps
LD_START  in  1  one-cycle pulse that opens a load burst at LD_BASE
LD_BASE  in  ADDR_W  start word address of the load burst
LD_VALID  in  1  LD_DATA is valid this cycle
LD_DATA  in  DATA_W  word to write
LD_END  in  1  closes the load burst
BUSY  out  1  1 while in LOAD state
ERR  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (RST=0 at posedge):
  - state=IDLE; MEM_OUT=0; RD_CNT=0; BUSY=0; ERR=0
  - strobe-history register=0; load pointer=0
  - array contents are not cleared
  - reset overrides everything, including a load burst in progress; words already written stay written
- Strobe detect: rise = MEM_CLK & ~mclk_q, where mclk_q is MEM_CLK registered every cycle.
  - A strobe held high for N cycles counts as one read.
- States: IDLE, LOAD, READ.
- IDLE:
  - rise and LD_START in the same cycle: LD_START wins and the read is dropped (ERR is not set).
  - rise: go to READ and latch the read result into MEM_OUT at this same posedge.
  - LD_START: go to LOAD with pointer=LD_BASE.
- READ read path:
  - MEM_OUT <= mem[MEM_ADDR[log2(DEPTH)-1:0]] when MEM_ADDR < DEPTH.
  - Otherwise MEM_OUT <= 0 and ERR <= 1.
  - RD_CNT increments.
  - Latency: strobe cycle k, data valid from cycle k+1. The fetch stage samples MEM_OUT in the cycle after its strobe, so this latency is fixed.
- READ: lasts exactly one cycle. Next state is IDLE, or LOAD if LD_START=1. A rise in this cycle is impossible because mclk_q=1 after the strobe.
- MEM_OUT holds its value until the next accepted read. It is not cleared on return to IDLE.
- LOAD:
  - BUSY=1.
  - Each cycle with LD_VALID=1 and pointer < DEPTH: mem[pointer] <= LD_DATA, then pointer+1.
  - LD_VALID=1 with pointer >= DEPTH: write dropped, ERR <= 1, pointer does not advance.
  - LD_END: return to IDLE. If LD_VALID is also 1 in that cycle, that final word is written first.
  - LD_START in LOAD: restarts the burst at the new LD_BASE and ignores LD_VALID that cycle.
  - A rise in LOAD is rejected: MEM_OUT unchanged, RD_CNT unchanged, ERR <= 1.
- Width rules:
  - pointer is ADDR_W+1 bits, so the out-of-range check never wraps.
  - RD_CNT wraps 0xFFFF -> 0.
- The array is write-first only within a load. Reads never occur in the same cycle as writes.

Test Plan:
- Reset then idle: RST=0 for 2 cycles -> MEM_OUT=0, RD_CNT=0, BUSY=0, ERR=0; after release all remain 0 with MEM_CLK=0.
- Load and read back: LD_START with LD_BASE=0x0010, then 3 LD_VALID words 0xA1,0xB2,0xC3, LD_END -> BUSY=1 for the burst. Strobe with MEM_ADDR=0x0011 -> MEM_OUT=0xB2 the next cycle and held until the next strobe; RD_CNT=1.
- Fetch-style cadence: repeating 7-cycle pattern with strobe 1 cycle high at PC=0,1,2 -> each word is valid in the cycle after its strobe; RD_CNT=3. A strobe held 3 cycles gives RD_CNT+1 only.
- Out of range:
  - strobe at MEM_ADDR=0x0100 (DEPTH=256) -> MEM_OUT=0, ERR=1.
  - load at LD_BASE=0x00FF with 2 words -> mem[0xFF] written, second word dropped, ERR=1.
- Collisions:
  - strobe during LOAD -> MEM_OUT unchanged, ERR=1.
  - LD_START and rise in the same IDLE cycle -> enters LOAD, no read, ERR=0.
- Reset mid-load: RST=0 after 2 of 4 words -> state IDLE, BUSY=0; the 2 written words read back correctly; remaining addresses keep their old contents.

Source files
------------

// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Memory side of the instruction-fetch interface. The fetch stage raises
// MEM_CLK for a cycle with a word address on MEM_ADDR. The addressed word
// appears on MEM_OUT one CLK later and stays there until the next accepted
// read. A streaming load port (LD_START / LD_VALID / LD_END) fills the array
// before or between program runs.
//
// Ports:
//   CLK       clock; every state change happens on its rising edge
//   RST       synchronous, active-low reset (array contents are kept)
//   MEM_CLK   read strobe from fetch, level sampled on CLK
//   MEM_ADDR  word address, valid while MEM_CLK=1
//   MEM_OUT   registered read data, held between reads
//   RD_CNT    count of accepted reads, wraps at 16 bits
//   LD_START  one-cycle pulse opening a load burst at LD_BASE
//   LD_BASE   first word address of the burst
//   LD_VALID  LD_DATA carries a word this cycle
//   LD_DATA   word to write
//   LD_END    closes the burst (a word valid in the same cycle is written)
//   BUSY      high while a load burst is open
//   ERR       sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module inst_mem_responder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MEM_CLK,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_OUT,
    output logic [15:0]       RD_CNT,
    input  logic              LD_START,
    input  logic [ADDR_W-1:0] LD_BASE,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_END,
    output logic              BUSY,
    output logic              ERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Depth expressed in the one-bit-wider pointer width so that range
    // checks on both the read address and the load pointer never wrap.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                mclk_q;
    logic                rise;
    logic [ADDR_W:0]     ptr;
    logic [ADDR_W:0]     ptr_next;
    logic [DATA_W-1:0]   mem_out_next;
    logic [15:0]         rd_cnt_next;
    logic                err_next;
    logic                we;
    logic [IDX_W-1:0]    waddr;
    logic                addr_ok;
    logic                ptr_ok;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    // A strobe held high for several cycles is a single read: only the
    // 0->1 transition of MEM_CLK counts.
    assign rise    = MEM_CLK & ~mclk_q;
    assign addr_ok = {1'b0, MEM_ADDR} < DEPTH_X;
    assign ptr_ok  = ptr < DEPTH_X;
    assign rd_word = mem[MEM_ADDR[IDX_W-1:0]];
    assign BUSY    = (state == LOAD);

    // Control and output registers; reset leaves the array untouched.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            mclk_q  <= 1'b0;
            ptr     <= '0;
            MEM_OUT <= '0;
            RD_CNT  <= '0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_next;
            mclk_q  <= MEM_CLK;
            ptr     <= ptr_next;
            MEM_OUT <= mem_out_next;
            RD_CNT  <= rd_cnt_next;
            ERR     <= err_next;
        end
    end

    // Array write port. Gated by RST so a reset arriving mid-burst drops
    // the word presented in that cycle.
    always_ff @(posedge CLK) begin
        if (RST && we) begin
            mem[waddr] <= LD_DATA;
        end
    end

    // Next-state and datapath decisions. The read result is captured on the
    // same edge that moves IDLE -> READ, so data is valid the cycle after
    // the strobe; READ itself is a one-cycle turnaround.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        mem_out_next = MEM_OUT;
        rd_cnt_next  = RD_CNT;
        err_next     = ERR;
        we           = 1'b0;
        waddr        = ptr[IDX_W-1:0];

        case (state)
            IDLE: begin
                // A load request beats a simultaneous strobe; the read is
                // silently dropped.
                if (LD_START) begin
                    state_next = LOAD;
                    ptr_next   = {1'b0, LD_BASE};
                end else if (rise) begin
                    state_next  = READ;
                    rd_cnt_next = RD_CNT + 16'd1;
                    if (addr_ok) begin
                        mem_out_next = rd_word;
                    end else begin
                        mem_out_next = '0;
                        err_next     = 1'b1;
                    end
                end
            end

            READ: begin
                if (LD_START) begin
                    state_next = LOAD;
                    ptr_next   = {1'b0, LD_BASE};
                end else begin
                    state_next = IDLE;
                end
            end

            LOAD: begin
                // Fetch must not read while the array is being filled.
                if (rise) begin
                    err_next = 1'b1;
                end
                if (LD_START) begin
                    ptr_next = {1'b0, LD_BASE};
                end else begin
                    if (LD_VALID) begin
                        if (ptr_ok) begin
                            we       = 1'b1;
                            ptr_next = ptr + PTR_ONE;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    if (LD_END) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
